// File: rtl/mem_access_if.sv
// Bus bundle between the EX stage, the MEM-stage sequencer, DataMemory and
// the write-back consumer. The slave side is the sequencer itself.
interface mem_access_if #(
    parameter int CNT_W = 16
);
    // EX-stage request
    logic              req_valid;
    logic              req_ready;
    logic              req_load;
    logic              req_store;
    logic              req_bw;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;

    // DataMemory ports
    logic [31:0]       Addr;
    logic [31:0]       WriteData;
    logic              MemRead;
    logic              MemWrite;
    logic              BW;
    logic [31:0]       ReadData;

    // Write-back result and debug
    logic              wb_valid;
    logic [31:0]       wb_data;
    logic [4:0]        wb_rd;
    logic              wb_regwrite;
    logic              wb_err;
    logic [31:0]       err_addr;
    logic [CNT_W-1:0]  load_cnt;
    logic [CNT_W-1:0]  store_cnt;
    logic [CNT_W-1:0]  err_cnt;

    modport slave (
        input  req_valid, req_load, req_store, req_bw, req_addr, req_wdata, req_rd,
        input  ReadData,
        output req_ready,
        output Addr, WriteData, MemRead, MemWrite, BW,
        output wb_valid, wb_data, wb_rd, wb_regwrite, wb_err,
        output err_addr, load_cnt, store_cnt, err_cnt
    );

    modport master (
        output req_valid, req_load, req_store, req_bw, req_addr, req_wdata, req_rd,
        output ReadData,
        input  req_ready,
        input  Addr, WriteData, MemRead, MemWrite, BW,
        input  wb_valid, wb_data, wb_rd, wb_regwrite, wb_err,
        input  err_addr, load_cnt, store_cnt, err_cnt
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: accepts one request, strobes DataMemory for
// a single cycle, formats the write-back result and rejects illegal accesses.
module mem_access_unit #(
    parameter int ADDR_BITS = 16,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    mem_access_if.slave bus
);
    typedef enum logic {IDLE, ACCESS} state_t;
    typedef enum logic [1:0] {K_LOAD, K_STORE, K_PASS, K_ERR} kind_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;
    kind_t             w_kind;
    logic              w_out_of_range;
    logic              w_misaligned;

    kind_t             r_kind;
    logic [4:0]        r_rd;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic              r_bw;
    logic              r_mem_read;
    logic              r_mem_write;

    logic              r_wb_valid;
    logic [31:0]       r_wb_data;
    logic [4:0]        r_wb_rd;
    logic              r_wb_regwrite;
    logic              r_wb_err;
    logic [31:0]       r_err_addr;
    logic [CNT_W-1:0]  r_load_cnt;
    logic [CNT_W-1:0]  r_store_cnt;
    logic [CNT_W-1:0]  r_err_cnt;

    // Any address bit above the implemented memory makes the access illegal.
    generate
        if (ADDR_BITS < 32) begin : g_range
            assign w_out_of_range = |bus.req_addr[31:ADDR_BITS];
        end else begin : g_full
            assign w_out_of_range = 1'b0;
        end
    endgenerate

    assign w_misaligned = bus.req_bw && (bus.req_addr[1:0] != 2'b00);

    // Classify the incoming request; errors take priority over load/store.
    always_comb begin
        w_kind = K_PASS;
        if ((bus.req_load && bus.req_store) || w_misaligned || w_out_of_range)
            w_kind = K_ERR;
        else if (bus.req_load)
            w_kind = K_LOAD;
        else if (bus.req_store)
            w_kind = K_STORE;
    end

    // Next-state logic: IDLE waits for a request, ACCESS always lasts one cycle.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ACCESS;
                end
            end
            ACCESS: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Latch the request on accept; Addr/WriteData/BW hold between accesses so
    // DataMemory never sees them change outside an accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kind  <= K_PASS;
            r_rd    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_bw    <= 1'b0;
        end else if (w_accept) begin
            r_kind  <= w_kind;
            r_rd    <= bus.req_rd;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_bw    <= bus.req_bw;
        end
    end

    // Strobes are high only in the cycle right after a legal accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_mem_read  <= w_accept && (w_kind == K_LOAD);
            r_mem_write <= w_accept && (w_kind == K_STORE);
        end
    end

    // Register the write-back result and debug counters as ACCESS ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid    <= 1'b0;
            r_wb_data     <= '0;
            r_wb_rd       <= '0;
            r_wb_regwrite <= 1'b0;
            r_wb_err      <= 1'b0;
            r_err_addr    <= '0;
            r_load_cnt    <= '0;
            r_store_cnt   <= '0;
            r_err_cnt     <= '0;
        end else if (r_state == ACCESS) begin
            r_wb_valid    <= 1'b1;
            r_wb_rd       <= r_rd;
            r_wb_err      <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_wb_data     <= '0;
            unique case (r_kind)
                K_LOAD: begin
                    r_wb_data     <= r_bw ? bus.ReadData : {24'b0, bus.ReadData[7:0]};
                    r_wb_regwrite <= (r_rd != 5'd0);
                    r_load_cnt    <= r_load_cnt + CNT_W'(1);
                end
                K_STORE: begin
                    r_store_cnt   <= r_store_cnt + CNT_W'(1);
                end
                K_PASS: begin
                    r_wb_data     <= r_wdata;
                    r_wb_regwrite <= (r_rd != 5'd0);
                end
                K_ERR: begin
                    r_wb_err      <= 1'b1;
                    r_err_addr    <= r_addr;
                    r_err_cnt     <= r_err_cnt + CNT_W'(1);
                end
            endcase
        end else begin
            r_wb_valid    <= 1'b0;
            r_wb_err      <= 1'b0;
            r_wb_regwrite <= 1'b0;
        end
    end

    assign bus.req_ready   = (r_state == IDLE);
    assign bus.Addr        = r_addr;
    assign bus.WriteData   = r_wdata;
    assign bus.BW          = r_bw;
    assign bus.MemRead     = r_mem_read;
    assign bus.MemWrite    = r_mem_write;
    assign bus.wb_valid    = r_wb_valid;
    assign bus.wb_data     = r_wb_data;
    assign bus.wb_rd       = r_wb_rd;
    assign bus.wb_regwrite = r_wb_regwrite;
    assign bus.wb_err      = r_wb_err;
    assign bus.err_addr    = r_err_addr;
    assign bus.load_cnt    = r_load_cnt;
    assign bus.store_cnt   = r_store_cnt;
    assign bus.err_cnt     = r_err_cnt;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed requests against a byte-array
// DataMemory, a per-cycle reference model, and literal spot checks.
module tb_mem_access_unit;
    localparam int KL = 0, KS = 1, KP = 2, KE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    mem_access_if #(.CNT_W(16)) bus ();

    mem_access_unit #(.ADDR_BITS(16), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // DataMemory: byte array, little-endian words, combinational read.
    logic [7:0] dmem [0:65535];
    logic [7:0] rmem [0:65535];

    always_comb begin
        int a;
        a = int'(bus.Addr[15:0]);
        bus.ReadData = '0;
        if (bus.BW)
            bus.ReadData = {dmem[(a + 3) & 16'hFFFF], dmem[(a + 2) & 16'hFFFF],
                            dmem[(a + 1) & 16'hFFFF], dmem[a]};
        else
            bus.ReadData = {24'b0, dmem[a]};
    end

    always @(posedge clk) begin
        int a;
        a = int'(bus.Addr[15:0]);
        if (bus.MemWrite) begin
            if (bus.BW) begin
                dmem[a]     <= bus.WriteData[7:0];
                dmem[a + 1] <= bus.WriteData[15:8];
                dmem[a + 2] <= bus.WriteData[23:16];
                dmem[a + 3] <= bus.WriteData[31:24];
            end else begin
                dmem[a] <= bus.WriteData[7:0];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int classify(input logic ld, input logic st, input logic bw,
                                    input logic [31:0] a);
        if ((ld && st) || (bw && (a % 4 != 0)) || (a >= 32'h0001_0000)) return KE;
        if (ld) return KL;
        if (st) return KS;
        return KP;
    endfunction

    // Reference model: what each cycle must look like, derived from the
    // accept/strobe/write-back timeline rather than any state encoding.
    logic        m_busy = 1'b0;
    int          m_kind = KP;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic        m_bw = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [31:0] exp_addr = '0, exp_wdata = '0;
    logic        exp_bw = 1'b0;
    logic        exp_wbv = 1'b0, exp_rw = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_data = '0, m_err_addr = '0;
    logic [4:0]  exp_rd = '0;
    logic [15:0] m_load = '0, m_store = '0, m_errc = '0;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0; exp_wbv = 1'b0;
            exp_addr = '0; exp_wdata = '0; exp_bw = 1'b0;
            m_err_addr = '0; m_load = '0; m_store = '0; m_errc = '0;
        end
        chk("req_ready", 32'(bus.req_ready), 32'(!m_busy));
        chk("MemRead",   32'(bus.MemRead),   32'(m_busy && m_kind == KL));
        chk("MemWrite",  32'(bus.MemWrite),  32'(m_busy && m_kind == KS));
        chk("Addr",      bus.Addr,      exp_addr);
        chk("WriteData", bus.WriteData, exp_wdata);
        chk("BW",        32'(bus.BW),   32'(exp_bw));
        chk("wb_valid",  32'(bus.wb_valid), 32'(exp_wbv));
        if (exp_wbv) begin
            chk("wb_data",     bus.wb_data,          exp_data);
            chk("wb_rd",       32'(bus.wb_rd),       32'(exp_rd));
            chk("wb_regwrite", 32'(bus.wb_regwrite), 32'(exp_rw));
            chk("wb_err",      32'(bus.wb_err),      32'(exp_err));
        end
        chk("err_addr",  bus.err_addr,        m_err_addr);
        chk("load_cnt",  32'(bus.load_cnt),   32'(m_load));
        chk("store_cnt", 32'(bus.store_cnt),  32'(m_store));
        chk("err_cnt",   32'(bus.err_cnt),    32'(m_errc));
        if (!rst) begin
            if (m_busy) begin
                int a;
                logic [31:0] w;
                a = int'(m_addr[15:0]);
                w = {rmem[(a + 3) & 16'hFFFF], rmem[(a + 2) & 16'hFFFF],
                     rmem[(a + 1) & 16'hFFFF], rmem[a]};
                exp_wbv = 1'b1; exp_rd = m_rd; exp_err = 1'b0; exp_rw = 1'b0; exp_data = '0;
                case (m_kind)
                    KL: begin
                        exp_data = m_bw ? w : (w & 32'hFF);
                        exp_rw = (m_rd != 0);
                        m_load = m_load + 1;
                    end
                    KS: begin
                        rmem[a] = m_wdata[7:0];
                        if (m_bw) begin
                            rmem[a + 1] = m_wdata[15:8];
                            rmem[a + 2] = m_wdata[23:16];
                            rmem[a + 3] = m_wdata[31:24];
                        end
                        m_store = m_store + 1;
                    end
                    KP: begin
                        exp_data = m_wdata;
                        exp_rw = (m_rd != 0);
                    end
                    default: begin
                        exp_err = 1'b1;
                        m_err_addr = m_addr;
                        m_errc = m_errc + 1;
                    end
                endcase
                m_busy = 1'b0;
            end else begin
                exp_wbv = 1'b0;
                if (bus.req_valid) begin
                    m_kind = classify(bus.req_load, bus.req_store, bus.req_bw, bus.req_addr);
                    m_addr = bus.req_addr; m_wdata = bus.req_wdata;
                    m_bw = bus.req_bw; m_rd = bus.req_rd;
                    exp_addr = m_addr; exp_wdata = m_wdata; exp_bw = m_bw;
                    m_busy = 1'b1;
                end
            end
        end
    end

    // One request: present it in IDLE, sample the ACCESS cycle, then the
    // write-back cycle. Entered and left at posedge+1 with the unit in IDLE.
    logic        s_rd, s_wr, s_bw, w_v, w_rw, w_err;
    logic [31:0] s_wdata, w_data;

    task automatic send(input logic ld, input logic st, input logic bw,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        bus.req_valid = 1'b1; bus.req_load = ld; bus.req_store = st;
        bus.req_bw = bw; bus.req_addr = a; bus.req_wdata = wd; bus.req_rd = rd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        s_rd = bus.MemRead; s_wr = bus.MemWrite; s_bw = bus.BW; s_wdata = bus.WriteData;
        @(posedge clk); #1;
        w_v = bus.wb_valid; w_data = bus.wb_data; w_rw = bus.wb_regwrite; w_err = bus.wb_err;
        $display("txn ld=%0d st=%0d bw=%0d addr=%h wd=%h rd=%0d | rd=%0d wr=%0d | wb_v=%0d data=%h rw=%0d err=%0d",
                 ld, st, bw, a, wd, rd, s_rd, s_wr, w_v, w_data, w_rw, w_err);
    endtask

    initial begin
        int pulses;
        for (int i = 0; i < 65536; i++) begin
            dmem[i] = 8'h00;
            rmem[i] = 8'h00;
        end
        dmem[0] = 8'h04; dmem[1] = 8'h13; dmem[2] = 8'h47; dmem[3] = 8'h00;
        dmem[5] = 8'h8F; dmem[32'h32] = 8'h07;
        rmem[0] = 8'h04; rmem[1] = 8'h13; rmem[2] = 8'h47; rmem[3] = 8'h00;
        rmem[5] = 8'h8F; rmem[32'h32] = 8'h07;

        bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_store = 1'b0; bus.req_bw = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset Addr", bus.Addr, 32'd0);

        // LW 0x0
        send(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 5'd8);
        chk("lw0 MemRead", 32'(s_rd), 32'd1);
        chk("lw0 wb_valid", 32'(w_v), 32'd1);
        chk("lw0 wb_data", w_data, 32'h0047_1304);
        chk("lw0 wb_regwrite", 32'(w_rw), 32'd1);
        chk("lw0 MemRead after", 32'(bus.MemRead), 32'd0);
        chk("lw0 load_cnt", 32'(bus.load_cnt), 32'd1);

        // LBU 0x5, LBU 0x32
        send(1'b1, 1'b0, 1'b0, 32'h5, 32'h0, 5'd9);
        chk("lbu5 BW", 32'(s_bw), 32'd0);
        chk("lbu5 wb_data", w_data, 32'h0000_008F);
        send(1'b1, 1'b0, 1'b0, 32'h32, 32'h0, 5'd9);
        chk("lbu32 BW", 32'(s_bw), 32'd0);
        chk("lbu32 wb_data", w_data, 32'h0000_0007);

        // SW 0x40 then LW 0x40
        send(1'b0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 5'd0);
        chk("sw MemWrite", 32'(s_wr), 32'd1);
        chk("sw WriteData", s_wdata, 32'hDEAD_BEEF);
        chk("sw wb_regwrite", 32'(w_rw), 32'd0);
        chk("sw store_cnt", 32'(bus.store_cnt), 32'd1);
        send(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 5'd10);
        chk("lw40 wb_data", w_data, 32'hDEAD_BEEF);

        // Misaligned word, then out-of-range byte store
        send(1'b1, 1'b0, 1'b1, 32'h2, 32'h0, 5'd3);
        chk("lw2 MemRead", 32'(s_rd), 32'd0);
        chk("lw2 wb_err", 32'(w_err), 32'd1);
        chk("lw2 err_addr", bus.err_addr, 32'h0000_0002);
        send(1'b0, 1'b1, 1'b0, 32'h0001_0000, 32'h55, 5'd0);
        chk("sb oor MemWrite", 32'(s_wr), 32'd0);
        chk("sb oor wb_err", 32'(w_err), 32'd1);
        chk("sb oor err_addr", bus.err_addr, 32'h0001_0000);
        chk("sb oor err_cnt", 32'(bus.err_cnt), 32'd2);

        // Load and store both set
        send(1'b1, 1'b1, 1'b1, 32'h8, 32'h0, 5'd4);
        chk("ldst wb_err", 32'(w_err), 32'd1);
        chk("ldst err_cnt", 32'(bus.err_cnt), 32'd3);

        // Pass-through with rd=0
        send(1'b0, 1'b0, 1'b0, 32'h0, 32'h1234, 5'd0);
        chk("pass wb_data", w_data, 32'h0000_1234);
        chk("pass wb_regwrite", 32'(w_rw), 32'd0);

        // Back-to-back: valid held for six edges gives three results
        bus.req_valid = 1'b1; bus.req_load = 1'b0; bus.req_store = 1'b0;
        bus.req_wdata = 32'h0000_0ABC; bus.req_rd = 5'd7;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.wb_valid) pulses++;
        end
        bus.req_valid = 1'b0;
        $display("txn back-to-back pass x6 edges -> %0d results", pulses);
        chk("b2b pulses", 32'(pulses), 32'd3);

        // Reset in the middle of SW 0x44
        bus.req_valid = 1'b1; bus.req_load = 1'b0; bus.req_store = 1'b1; bus.req_bw = 1'b1;
        bus.req_addr = 32'h44; bus.req_wdata = 32'hCAFE_F00D; bus.req_rd = 5'd0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("rstmid MemWrite before", 32'(bus.MemWrite), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rstmid MemWrite", 32'(bus.MemWrite), 32'd0);
        chk("rstmid req_ready", 32'(bus.req_ready), 32'd1);
        chk("rstmid store_cnt", 32'(bus.store_cnt), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid mem untouched", 32'(dmem[32'h44]), 32'd0);
        chk("rstmid load_cnt", 32'(bus.load_cnt), 32'd0);
        $display("txn reset during SW 0x44 -> wb_valid=%0d req_ready=%0d", bus.wb_valid, bus.req_ready);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
